// File: rtl/gcd_pkg.sv
// gcd_pkg: FSM state encoding and default operand width shared by the GCD engine
package gcd_pkg;
  typedef enum logic [1:0] {GCD_IDLE, GCD_CALC, GCD_DONE} gcd_state_t;
  localparam int GCD_WIDTH = 16;
endpackage

// File: rtl/gcd_sub_cmp.sv
// gcd_sub_cmp: operand compare flags and larger-minus-smaller difference
module gcd_sub_cmp
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             a_gt_b_o,
  output logic             a_eq_b_o,
  output logic             a_zero_o,
  output logic             b_zero_o,
  output logic [WIDTH-1:0] diff_o
);
  assign a_gt_b_o = a_i > b_i;
  assign a_eq_b_o = a_i == b_i;
  assign a_zero_o = a_i == '0;
  assign b_zero_o = b_i == '0;
  assign diff_o   = a_gt_b_o ? a_i - b_i : b_i - a_i;
endmodule

// File: rtl/gcd_engine.sv
// gcd_engine: subtractive GCD over valid/ready; define GCD_ITER_COUNT_EN for the saturating out_iter step counter
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
`ifdef GCD_ITER_COUNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd
`ifdef GCD_ITER_COUNT_EN
  , output logic [CNT_W-1:0] out_iter
`endif
);
  gcd_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff;
  logic             a_gt_b, a_eq_b, a_zero, b_zero, finish;
  gcd_sub_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a_i      (a_q),
    .b_i      (b_q),
    .a_gt_b_o (a_gt_b),
    .a_eq_b_o (a_eq_b),
    .a_zero_o (a_zero),
    .b_zero_o (b_zero),
    .diff_o   (diff)
  );
  assign finish  = b_zero | a_zero | a_eq_b;
  assign out_gcd = a_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      GCD_IDLE: begin
        state_d = in_valid && in_ready ? GCD_CALC : GCD_IDLE;
        a_d     = in_valid && in_ready ? in_a : a_q;
        b_d     = in_valid && in_ready ? in_b : b_q;
      end
      GCD_CALC: begin
        state_d = finish ? GCD_DONE : GCD_CALC;
        a_d     = finish ? (a_zero ? b_q : a_q) : (a_gt_b ? diff : a_q);
        b_d     = finish || a_gt_b ? b_q : diff;
      end
      GCD_DONE: state_d = out_ready ? GCD_IDLE : GCD_DONE;
      default:  state_d = GCD_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= GCD_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      in_ready  <= state_d == GCD_IDLE;
      out_valid <= state_d == GCD_DONE;
    end
  end
`ifdef GCD_ITER_COUNT_EN
  logic [CNT_W-1:0] iter_q, iter_d;
  assign out_iter = iter_q;
  always_comb begin
    iter_d = iter_q;
    if (state_q == GCD_IDLE && in_valid && in_ready)
      iter_d = '0;
    else if (state_q == GCD_CALC && !finish)
      iter_d = &iter_q ? iter_q : iter_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) iter_q <= '0;
    else        iter_q <= iter_d;
  end
`endif
endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: directed vectors checked against a Euclid-division reference model every cycle
module tb_gcd_engine;
  localparam int W = 16;
  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_a, in_b, out_gcd;
`ifdef GCD_ITER_COUNT_EN
  logic [15:0]  out_iter;
`endif
  int errors = 0, checks = 0;
  bit chk_en = 0;
  int m_phase = 0, m_cnt = 0, m_gcd = 0, m_iter = 0;
  gcd_engine #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gcd   (out_gcd)
`ifdef GCD_ITER_COUNT_EN
    , .out_iter (out_iter)
`endif
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic int euclid(input int a, input int b, input bit want_steps);
    int k = 0;
    if (a == 0 || b == 0) return want_steps ? 0 : a + b;
    while (a != b) begin
      if (a > b) begin
        k += (a % b == 0) ? a / b - 1 : a / b;
        a  = (a % b == 0) ? b : a % b;
      end else begin
        k += (b % a == 0) ? b / a - 1 : b / a;
        b  = (b % a == 0) ? a : b % a;
      end
    end
    return want_steps ? k : a;
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // transaction-level model: 0 idle, 1 computing (m_cnt edges left), 2 result held
  always @(posedge clk) begin
    if (!rst_n) m_phase <= 0;
    else case (m_phase)
      0: if (in_valid) begin
        m_phase <= 1;
        m_gcd   <= euclid(int'(in_a), int'(in_b), 0);
        m_iter  <= euclid(int'(in_a), int'(in_b), 1);
        m_cnt   <= euclid(int'(in_a), int'(in_b), 1) + 1;
      end
      1: begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_phase <= 2;
      end
      default: if (out_ready) m_phase <= 0;
    endcase
  end
  always @(negedge clk) if (chk_en) begin
    check("in_ready", in_ready, m_phase == 0);
    check("out_valid", out_valid, m_phase == 2);
    if (m_phase == 2) begin
      check("out_gcd", out_gcd, m_gcd);
`ifdef GCD_ITER_COUNT_EN
      check("out_iter", out_iter, m_iter);
`endif
    end
  end
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 70000) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic run(input int a, input int b, input int g, input int k);
    int lat;
    @(negedge clk);
    in_valid = 1; in_a = W'(a); in_b = W'(b);
    @(negedge clk);
    in_valid = 0;
    wait_done(lat);
    check($sformatf("lat(%0d,%0d)", a, b), lat, k + 1);
    check($sformatf("gcd(%0d,%0d)", a, b), out_gcd, g);
`ifdef GCD_ITER_COUNT_EN
    check($sformatf("iter(%0d,%0d)", a, b), out_iter, k);
`endif
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask
  initial begin
    int lat;
    rst_n = 0; in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_gcd", out_gcd, 0);
    check("model_gcd_12_8", euclid(12, 8, 0), 4);
    check("model_steps_12_8", euclid(12, 8, 1), 2);
    check("model_steps_65535_1", euclid(65535, 1, 1), 65534);
    rst_n = 1;
    run(12, 8, 4, 2);
    run(7, 7, 7, 0);
    run(0, 9, 9, 0);
    run(9, 0, 9, 0);
    run(0, 0, 0, 0);
    run(21, 6, 3, 4);
    run(17, 5, 1, 6);
    run(65535, 1, 1, 65534);
    // in_valid pulses during CALC and a stalled DONE must be ignored
    @(negedge clk);
    in_valid = 1; in_a = 12; in_b = 8;
    @(negedge clk);
    in_a = 3; in_b = 3;
    check("calc_in_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 0;
    wait_done(lat);
    check("stall_lat", lat, 2);
    repeat (5) begin
      in_valid = 1;
      @(negedge clk);
      check("stall_gcd", out_gcd, 4);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0; in_valid = 0;
    check("retire_in_ready", in_ready, 1);
    // reset abandons a calculation in flight
    @(negedge clk);
    in_valid = 1; in_a = 48; in_b = 18;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    run(48, 18, 6, 4);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
